pipe_hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage SPARC core. Each cycle it produces the PC, nPC and pipeline-register enable/flush controls from three inputs: I-cache and D-cache busy status, load-use hazards between ID/EX and IF/ID, and branch redirects resolved in the EX/Mem register. It holds redirects that arrive during a D-cache stall and drains a wrong-path I-cache fetch before loading a branch target. It keeps stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/nPC advance, register enables/flushes, redirect hold and perf counters.
// Latency: controls are combinational from state, pend and inputs; state and counters update on the clock edge.
// Backpressure: dc_busy freezes every stage; ic_busy or a load-use hazard stalls the front end only.
module pipe_hazard_ctrl #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_busy,
   input  logic              dc_busy,
   input  logic              redirect_req,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              annul_ds,
   input  logic              idex_is_load,
   input  logic              idex_is_ldd,
   input  logic [4:0]        idex_rd,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_rs1_v,
   input  logic              id_rs2_v,
   output logic              pc_en,
   output logic              npc_load,
   output logic [ADDR_W-1:0] npc_target,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              memwb_flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {RUN, DSTALL, DROP} state_t;

   state_t            state, state_nx;
   logic              pend_v;
   logic [ADDR_W-1:0] pend_tgt;
   logic              pend_annul;

   logic              eff_v;
   logic [ADDR_W-1:0] eff_tgt;
   logic              eff_annul;
   logic              hazard;
   logic              rs1_hit, rs2_hit;

   logic              c_pc_en, c_npc_load, c_ifid_en, c_idex_en, c_exmem_en, c_memwb_en;
   logic              c_ifid_flush, c_idex_flush, c_memwb_flush;
   logic              pend_set, pend_clr, flush_inc;

   // A held redirect always takes precedence over a new one (upstream never overlaps them)
   always_comb begin
      eff_v     = pend_v | redirect_req;
      eff_tgt   = pend_v ? pend_tgt   : redirect_target;
      eff_annul = pend_v ? pend_annul : annul_ds;
   end

   // Load-use detection; a doubleword load writes the even/odd pair so only [4:1] is compared
   always_comb begin
      rs1_hit = id_rs1_v && (id_rs1 != 5'd0) &&
                (idex_is_ldd ? (id_rs1[4:1] == idex_rd[4:1]) : (id_rs1 == idex_rd));
      rs2_hit = id_rs2_v && (id_rs2 != 5'd0) &&
                (idex_is_ldd ? (id_rs2[4:1] == idex_rd[4:1]) : (id_rs2 == idex_rd));
      hazard  = (idex_is_load | idex_is_ldd) && (idex_rd != 5'd0) && (rs1_hit | rs2_hit);
   end

   // Per-cycle control decision; a DSTALL cycle whose D-cache ack has arrived behaves as RUN
   always_comb begin
      c_pc_en       = 1'b1;
      c_npc_load    = 1'b0;
      c_ifid_en     = 1'b1;
      c_idex_en     = 1'b1;
      c_exmem_en    = 1'b1;
      c_memwb_en    = 1'b1;
      c_ifid_flush  = 1'b0;
      c_idex_flush  = 1'b0;
      c_memwb_flush = 1'b0;
      pend_set      = 1'b0;
      pend_clr      = 1'b0;
      flush_inc     = 1'b0;
      state_nx      = state;
      if (dc_busy) begin
         c_pc_en       = 1'b0;
         c_ifid_en     = 1'b0;
         c_idex_en     = 1'b0;
         c_exmem_en    = 1'b0;
         c_memwb_en    = 1'b0;
         c_memwb_flush = 1'b1;
         pend_set      = redirect_req && !pend_v;
         state_nx      = (state == DROP) ? DROP : DSTALL;
      end else if (state == DROP) begin
         // Wrong-path fetch still in flight; its returning word is discarded too
         c_pc_en      = 1'b0;
         c_ifid_flush = 1'b1;
         if (!ic_busy) state_nx = RUN;
      end else begin
         state_nx = RUN;
         if (eff_v && ic_busy) begin
            c_pc_en      = 1'b0;
            c_ifid_flush = 1'b1;
            c_idex_flush = eff_annul;
            pend_set     = !pend_v;
            state_nx     = DROP;
         end else if (eff_v) begin
            c_npc_load   = 1'b1;
            c_ifid_flush = 1'b1;
            c_idex_flush = eff_annul;
            pend_clr     = 1'b1;
            flush_inc    = 1'b1;
         end else if (hazard) begin
            c_pc_en      = 1'b0;
            c_ifid_en    = 1'b0;
            c_idex_flush = 1'b1;
         end else if (ic_busy) begin
            c_pc_en      = 1'b0;
            c_ifid_flush = 1'b1;
         end
      end
   end

   // Reset forces every stage to hold a bubble
   always_comb begin
      pc_en       = reset & c_pc_en;
      npc_load    = reset & c_npc_load;
      npc_target  = (reset && c_npc_load) ? eff_tgt : '0;
      ifid_en     = reset & c_ifid_en;
      idex_en     = reset & c_idex_en;
      exmem_en    = reset & c_exmem_en;
      memwb_en    = reset & c_memwb_en;
      ifid_flush  = !reset | c_ifid_flush;
      idex_flush  = !reset | c_idex_flush;
      memwb_flush = !reset | c_memwb_flush;
   end

   // State, held redirect and performance counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= RUN;
         pend_v     <= 1'b0;
         pend_tgt   <= '0;
         pend_annul <= 1'b0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         state <= state_nx;
         if (pend_set) begin
            pend_v     <= 1'b1;
            pend_tgt   <= redirect_target;
            pend_annul <= annul_ds;
         end else if (pend_clr) begin
            pend_v <= 1'b0;
         end
         if (!c_pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
